// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions: next-PC select encodings, NOP word, fetch FSM states.
package cpu_defs_pkg;

    // Next-PC select encodings, shared with the control unit.
    localparam logic [2:0] PC_SEQ  = 3'b000;
    localparam logic [2:0] PC_BEQ  = 3'b001;
    localparam logic [2:0] PC_BNE  = 3'b010;
    localparam logic [2:0] PC_JUMP = 3'b011;
    localparam logic [2:0] PC_JR   = 3'b100;

    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StFetch = 2'b01,
        StValid = 2'b10
    } fetch_state_e;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction memory request/acknowledge bus.
interface instr_fetch_unit_if #(
    parameter int unsigned ADDR_WIDTH = 32
);
    logic                  req;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  ack;
    logic [31:0]           rdata;

    modport master (output req, output addr, input ack, input rdata);
    modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/instr_fetch_unit_next_pc.sv
// Combinational next-PC selection for the presented instruction.
module next_pc_calc
    import cpu_defs_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic [ADDR_WIDTH-1:0] pc,
    input  logic [2:0]            pc_control,
    input  logic                  alu_zero,
    input  logic [15:0]           branch_imm,
    input  logic [25:0]           jump_index,
    input  logic [ADDR_WIDTH-1:0] jr_target,
    output logic [ADDR_WIDTH-1:0] next_pc,
    output logic                  misalign
);

    logic [ADDR_WIDTH-1:0] pc_plus4;
    logic [ADDR_WIDTH-1:0] br_off;
    logic [ADDR_WIDTH-1:0] br_target;

    // Select the next PC; all arithmetic wraps modulo 2^ADDR_WIDTH.
    always_comb begin
        pc_plus4  = pc + ADDR_WIDTH'(4);
        br_off    = {{(ADDR_WIDTH - 18){branch_imm[15]}}, branch_imm, 2'b00};
        br_target = pc_plus4 + br_off;
        next_pc   = pc_plus4;
        misalign  = 1'b0;
        case (pc_control)
            PC_BEQ:  if (alu_zero)  next_pc = br_target;
            PC_BNE:  if (!alu_zero) next_pc = br_target;
            PC_JUMP: next_pc = {pc_plus4[ADDR_WIDTH-1:28], jump_index, 2'b00};
            PC_JR: begin
                next_pc  = {jr_target[ADDR_WIDTH-1:2], 2'b00};
                misalign = |jr_target[1:0];
            end
            default: ;  // SEQ and reserved encodings fall through to pc+4
        endcase
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// PC register, fetch handshake FSM, instruction register and retire counter.
module instr_fetch_unit
    import cpu_defs_pkg::*;
#(
    parameter int unsigned          ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC  = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [2:0]            pc_control,
    input  logic                  alu_zero,
    input  logic [15:0]           branch_imm,
    input  logic [25:0]           jump_index,
    input  logic [ADDR_WIDTH-1:0] jr_target,
    input  logic                  stall,
    instr_fetch_unit_if.master    imem,
    output logic [31:0]           instruction,
    output logic                  instr_valid,
    output logic [ADDR_WIDTH-1:0] pc_out,
    output logic [ADDR_WIDTH-1:0] pc_plus4,
    output logic [31:0]           instret,
    output logic                  misalign_err
);

    fetch_state_e          state_d, state_q;
    logic [ADDR_WIDTH-1:0] pc_d, pc_q;
    logic [31:0]           ir_d, ir_q;
    logic                  valid_d, valid_q;
    logic                  req_d, req_q;
    logic [31:0]           instret_d, instret_q;
    logic                  mis_d, mis_q;

    logic [ADDR_WIDTH-1:0] next_pc;
    logic                  misalign;

    next_pc_calc #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_next_pc (
        .pc         (pc_q),
        .pc_control (pc_control),
        .alu_zero   (alu_zero),
        .branch_imm (branch_imm),
        .jump_index (jump_index),
        .jr_target  (jr_target),
        .next_pc    (next_pc),
        .misalign   (misalign)
    );

    // FSM next state: fetch until ack, present until retired (stall low).
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        valid_d   = valid_q;
        req_d     = req_q;
        instret_d = instret_q;
        mis_d     = mis_q;
        case (state_q)
            StIdle: begin
                state_d = StFetch;
                req_d   = 1'b1;
            end
            StFetch: begin
                if (imem.ack) begin
                    ir_d    = imem.rdata;
                    valid_d = 1'b1;
                    req_d   = 1'b0;
                    state_d = StValid;
                end
            end
            StValid: begin
                if (!stall) begin
                    pc_d      = next_pc;
                    instret_d = instret_q + 32'd1;
                    valid_d   = 1'b0;
                    req_d     = 1'b1;
                    state_d   = StFetch;
                    if (misalign) mis_d = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
                req_d   = 1'b0;
                valid_d = 1'b0;
            end
        endcase
    end

    // State registers; reset drops any in-flight request immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            pc_q      <= RESET_PC;
            ir_q      <= NOP_WORD;
            valid_q   <= 1'b0;
            req_q     <= 1'b0;
            instret_q <= 32'd0;
            mis_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            valid_q   <= valid_d;
            req_q     <= req_d;
            instret_q <= instret_d;
            mis_q     <= mis_d;
        end
    end

    assign imem.req     = req_q;
    assign imem.addr    = pc_q;
    assign instruction  = ir_q;
    assign instr_valid  = valid_q;
    assign pc_out       = pc_q;
    assign pc_plus4     = pc_q + ADDR_WIDTH'(4);
    assign instret      = instret_q;
    assign misalign_err = mis_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed, table-driven bench for instr_fetch_unit.
module tb_instr_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic [2:0]  pc_control;
    logic        alu_zero;
    logic [15:0] branch_imm;
    logic [25:0] jump_index;
    logic [31:0] jr_target;
    logic        stall;
    logic [31:0] instruction;
    logic        instr_valid;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4;
    logic [31:0] instret;
    logic        misalign_err;

    int passed = 0;
    int total  = 0;

    instr_fetch_unit_if #(.ADDR_WIDTH(32)) imem_bus ();

    instr_fetch_unit #(
        .ADDR_WIDTH (32),
        .RESET_PC   (32'h0000_0000)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pc_control   (pc_control),
        .alu_zero     (alu_zero),
        .branch_imm   (branch_imm),
        .jump_index   (jump_index),
        .jr_target    (jr_target),
        .stall        (stall),
        .imem         (imem_bus),
        .instruction  (instruction),
        .instr_valid  (instr_valid),
        .pc_out       (pc_out),
        .pc_plus4     (pc_plus4),
        .instret      (instret),
        .misalign_err (misalign_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] start_pc;
        logic [2:0]  ctl;
        logic        z;
        logic [15:0] imm;
        logic [25:0] idx;
        logic [31:0] jr;
        logic [31:0] exp_addr;
        logic        exp_mis;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Wait (bounded) at negedges until a fetch request is visible.
    task automatic wait_req();
        int n;
        n = 0;
        while (imem_bus.req !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (imem_bus.req !== 1'b1) begin
            total++;
            $display("FAIL wait_req: req never asserted within 50 cycles");
        end
    endtask

    // Serve the pending fetch after 'delay' idle cycles; returns in VALID.
    task automatic fetch_present(input logic [31:0] word, input int delay);
        wait_req();
        repeat (delay) @(negedge clk);
        imem_bus.ack   = 1'b1;
        imem_bus.rdata = word;
        @(negedge clk);
        imem_bus.ack   = 1'b0;
    endtask

    // Retire the presented instruction with the given next-PC controls.
    task automatic retire(input logic [2:0] ctl, input logic z, input logic [15:0] imm,
                          input logic [25:0] idx, input logic [31:0] jr);
        pc_control = ctl;
        alu_zero   = z;
        branch_imm = imm;
        jump_index = idx;
        jr_target  = jr;
        stall      = 1'b0;
        @(negedge clk);
        stall      = 1'b1;
    endtask

    initial begin
        // start_pc, ctl, z, imm, idx, jr, exp_addr, exp_mis
        vecs[0]  = '{32'h0000_0010, 3'b001, 1'b1, 16'hFFFC, 26'h0, 32'h0, 32'h0000_0004, 1'b0};
        vecs[1]  = '{32'h0000_0010, 3'b001, 1'b0, 16'hFFFC, 26'h0, 32'h0, 32'h0000_0014, 1'b0};
        vecs[2]  = '{32'h0000_0010, 3'b010, 1'b0, 16'h0003, 26'h0, 32'h0, 32'h0000_0020, 1'b0};
        vecs[3]  = '{32'h0000_0010, 3'b010, 1'b1, 16'h0003, 26'h0, 32'h0, 32'h0000_0014, 1'b0};
        vecs[4]  = '{32'h3000_0000, 3'b011, 1'b0, 16'h0, 26'h0000100, 32'h0, 32'h3000_0400, 1'b0};
        vecs[5]  = '{32'hFFFF_FFFC, 3'b000, 1'b1, 16'h1234, 26'h0, 32'h0, 32'h0000_0000, 1'b0};
        vecs[6]  = '{32'h0000_0040, 3'b111, 1'b1, 16'h0005, 26'h00ABCDE, 32'h999, 32'h0000_0044, 1'b0};
        vecs[7]  = '{32'h0000_0040, 3'b101, 1'b0, 16'h0005, 26'h0, 32'h888, 32'h0000_0044, 1'b0};
        vecs[8]  = '{32'h0FFF_FFFC, 3'b011, 1'b0, 16'h0, 26'h3FFFFFF, 32'h0, 32'h1FFF_FFFC, 1'b0};
        vecs[9]  = '{32'h0000_0100, 3'b100, 1'b0, 16'h0, 26'h0, 32'h0000_0102, 32'h0000_0100, 1'b1};
        vecs[10] = '{32'h0000_0200, 3'b001, 1'b1, 16'h7FFF, 26'h0, 32'h0, 32'h0002_0200, 1'b1};
        vecs[11] = '{32'hFFFF_FFF0, 3'b001, 1'b1, 16'h0004, 26'h0, 32'h0, 32'h0000_0004, 1'b1};

        rst_n = 1'b0;
        stall = 1'b1;
        pc_control = 3'b000;
        alu_zero = 1'b0;
        branch_imm = '0;
        jump_index = '0;
        jr_target = '0;
        imem_bus.ack = 1'b0;
        imem_bus.rdata = '0;
        @(negedge clk);
        @(negedge clk);

        check("rst_req", {31'd0, imem_bus.req}, 32'd0);
        check("rst_pc", pc_out, 32'h0);
        check("rst_valid", {31'd0, instr_valid}, 32'd0);
        check("rst_instr", instruction, 32'h0);
        check("rst_instret", instret, 32'd0);
        check("rst_mis", {31'd0, misalign_err}, 32'd0);

        // Immediate acks, no stall: one instruction every two cycles.
        rst_n = 1'b1;
        imem_bus.ack = 1'b1;
        imem_bus.rdata = 32'h2000_0001;
        stall = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("t1_valid%0d", i), {31'd0, instr_valid}, (i % 2 == 1) ? 32'd1 : 32'd0);
            if (i % 2 == 0) check($sformatf("t1_addr%0d", i), imem_bus.addr, 32'(2 * i));
            if (i == 1) check("t1_instr", instruction, 32'h2000_0001);
            @(negedge clk);
        end
        imem_bus.ack = 1'b0;
        stall = 1'b1;
        check("t1_instret", instret, 32'd3);

        // Slow memory: request and address held while ack is low.
        for (int i = 0; i < 5; i++) begin
            check($sformatf("t4_req%0d", i), {31'd0, imem_bus.req}, 32'd1);
            check($sformatf("t4_addr%0d", i), imem_bus.addr, 32'h0000_000C);
            @(negedge clk);
        end
        imem_bus.ack = 1'b1;
        imem_bus.rdata = 32'hCAFE_0001;
        @(negedge clk);
        imem_bus.ack = 1'b0;
        // Stall in VALID: everything held.
        for (int i = 0; i < 3; i++) begin
            check($sformatf("t4_st_instr%0d", i), instruction, 32'hCAFE_0001);
            check($sformatf("t4_st_pc%0d", i), pc_out, 32'h0000_000C);
            check($sformatf("t4_st_iret%0d", i), instret, 32'd3);
            check($sformatf("t4_st_valid%0d", i), {31'd0, instr_valid}, 32'd1);
            @(negedge clk);
        end
        retire(3'b000, 1'b0, 16'h0, 26'h0, 32'h0);
        check("t4_addr_after", imem_bus.addr, 32'h0000_0010);
        check("t4_instret_after", instret, 32'd4);

        // Table: position the PC with an aligned JR, then apply the vector.
        for (int i = 0; i < 12; i++) begin
            fetch_present(32'h1111_0000 + 32'(i), 0);
            retire(3'b100, 1'b0, 16'h0, 26'h0, vecs[i].start_pc);
            check($sformatf("v%0d_setup", i), imem_bus.addr, vecs[i].start_pc);
            fetch_present(32'hABCD_0000 + 32'(i), 1);
            check($sformatf("v%0d_pc", i), pc_out, vecs[i].start_pc);
            check($sformatf("v%0d_pc4", i), pc_plus4, vecs[i].start_pc + 32'd4);
            check($sformatf("v%0d_instr", i), instruction, 32'hABCD_0000 + 32'(i));
            retire(vecs[i].ctl, vecs[i].z, vecs[i].imm, vecs[i].idx, vecs[i].jr);
            check($sformatf("v%0d_req", i), {31'd0, imem_bus.req}, 32'd1);
            check($sformatf("v%0d_addr", i), imem_bus.addr, vecs[i].exp_addr);
            check($sformatf("v%0d_mis", i), {31'd0, misalign_err}, {31'd0, vecs[i].exp_mis});
        end

        // Asynchronous reset in the middle of a fetch at pc=0x20.
        fetch_present(32'h0, 0);
        retire(3'b100, 1'b0, 16'h0, 26'h0, 32'h0000_0020);
        check("t5_pre_addr", imem_bus.addr, 32'h0000_0020);
        #2 rst_n = 1'b0;
        #1;
        check("t5_req", {31'd0, imem_bus.req}, 32'd0);
        check("t5_pc", pc_out, 32'h0);
        check("t5_mis", {31'd0, misalign_err}, 32'd0);
        check("t5_instret", instret, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        wait_req();
        check("t5_first_addr", imem_bus.addr, 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
